ysyx_23060096_inst_sram: RTL

//  Instruction-fetch responder for the NPC core: accepts fetch requests (pc),

---
 rtl/ysyx_23060096_inst_sram_pkg.sv | 26 ++
 rtl/ysyx_23060096_sram_1r1w.sv | 33 +++
 rtl/ysyx_23060096_inst_sram.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ysyx_23060096_inst_sram_pkg.sv
// Shared definitions for the NPC instruction/data memory responders.
package ysyx_23060096_inst_sram_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } fetch_state_t;

    // Instruction word driven when no valid data is available (reset or error).
    localparam logic [31:0] ZERO_INST = '0;

    // True when addr is word-aligned and inside [base, base + 4*depth_words).
    // The offset shift is compared at full 32-bit width so that addresses far
    // above the window cannot alias back into it.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth_words
    );
        return (addr[1:0] == 2'b00) &&
               (addr >= base) &&
               (((addr - base) >> 2) < depth_words);
    endfunction

endpackage

// File: rtl/ysyx_23060096_sram_1r1w.sv
// Synchronous-read word array with one read and one write port.
// A read and a write to the same word on the same edge return the old word.
module ysyx_23060096_sram_1r1w #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read samples the pre-write contents on a collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ysyx_23060096_inst_sram.sv
// Instruction-fetch responder: accepts one fetch at a time, returns the
// addressed word LATENCY cycles later, and exposes a backdoor load port.
module ysyx_23060096_inst_sram
    import ysyx_23060096_inst_sram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("ysyx_23060096_inst_sram: LATENCY must be in 1..15");
        end
    endgenerate

    fetch_state_t   state;
    fetch_state_t   state_next;
    logic [3:0]     cnt;
    logic           accept;
    logic           req_ok;
    logic           load_ok;
    logic           data_ok;
    logic           err_q;
    logic [AW-1:0]  rd_idx;
    logic [AW-1:0]  wr_idx;
    logic [31:0]    rd_data;

    assign accept  = req_valid && req_ready;
    assign req_ok  = addr_in_range(req_addr, BASE_ADDR, 32'(DEPTH_WORDS));
    assign load_ok = addr_in_range(load_addr, BASE_ADDR, 32'(DEPTH_WORDS));
    assign rd_idx  = AW'((req_addr - BASE_ADDR) >> 2);
    assign wr_idx  = AW'((load_addr - BASE_ADDR) >> 2);

    ysyx_23060096_sram_1r1w #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (32)
    ) u_sram (
        .clk     (clk),
        .rd_en   (accept && req_ok),
        .rd_addr (rd_idx),
        .rd_data (rd_data),
        .wr_en   (load_en && load_ok),
        .wr_addr (wr_idx),
        .wr_data (load_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'(LATENCY - 1)) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Latency counter: cleared at accept, advances while waiting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Response attributes captured at accept and held until the next accept.
    // The SRAM output register carries the data itself; data_ok gates it so
    // reset and error responses read as zero without resetting the array.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_ok <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            data_ok <= req_ok;
            err_q   <= !req_ok;
        end
    end

    assign resp_inst = data_ok ? rd_data : ZERO_INST;
    assign resp_err  = err_q;

endmodule
